// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared types for the sequential ALU: op codes, FSM states and the flag
// bundle. Also a small helper that classifies shift op codes.
// ---------------------------------------------------------------------------
package alu_pkg;

    typedef enum logic [2:0] {
        OP_AND = 3'b000,
        OP_OR  = 3'b001,
        OP_XOR = 3'b010,
        OP_ADD = 3'b011,
        OP_SUB = 3'b100,
        OP_SLL = 3'b101,
        OP_SRA = 3'b110,
        OP_SRL = 3'b111
    } op_t;

    typedef enum logic [1:0] {
        REPOSO   = 2'd0,
        DESPLAZA = 2'd1,
        HECHO    = 2'd2
    } estado_t;

    typedef struct packed {
        logic cero;
        logic negativo;
        logic acarreo;
        logic desborde;
    } banderas_t;

    // Shift ops are the only multi-cycle ones.
    function automatic logic es_desplazamiento(input op_t op);
        return (op == OP_SLL) || (op == OP_SRA) || (op == OP_SRL);
    endfunction

endpackage

// File: rtl/unidad_desplazamiento.sv
// ---------------------------------------------------------------------------
// unidad_desplazamiento
// Serial shifter: one bit per clock, driven by a down-counter.
//   clk, rst  : clock, synchronous active-high reset
//   load      : capture dato/modo/cnt (start a new shift)
//   modo      : OP_SLL / OP_SRA / OP_SRL
//   dato      : value to shift
//   cnt       : number of single-bit steps (0 = nothing to do)
//   dato_out  : value after the step being taken this cycle
//   bit_out   : bit that leaves the register in this cycle's step
//   fin       : this cycle performs the last step
// dato_out/bit_out are combinational look-ahead so the owner can register
// the final value on the same edge the last step happens.
// ---------------------------------------------------------------------------
module unidad_desplazamiento
    import alu_pkg::*;
#(
    parameter int M  = 4,
    parameter int CW = $clog2(M + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  op_t           modo,
    input  logic [M-1:0]  dato,
    input  logic [CW-1:0] cnt,
    output logic [M-1:0]  dato_out,
    output logic          bit_out,
    output logic          fin
);

    logic [M-1:0]  dato_q, dato_d;
    logic [CW-1:0] cnt_q, cnt_d;
    op_t           modo_q, modo_d;

    // Single step from the current register contents.
    always_comb begin
        dato_out = {1'b0, dato_q[M-1:1]};
        bit_out  = dato_q[0];
        case (modo_q)
            OP_SLL: begin
                dato_out = {dato_q[M-2:0], 1'b0};
                bit_out  = dato_q[M-1];
            end
            OP_SRA: begin
                dato_out = {dato_q[M-1], dato_q[M-1:1]};
                bit_out  = dato_q[0];
            end
            default: begin
                dato_out = {1'b0, dato_q[M-1:1]};
                bit_out  = dato_q[0];
            end
        endcase
    end

    assign fin = (cnt_q == CW'(1));

    always_comb begin
        dato_d = dato_q;
        cnt_d  = cnt_q;
        modo_d = modo_q;
        if (load) begin
            dato_d = dato;
            cnt_d  = cnt;
            modo_d = modo;
        end else if (cnt_q != '0) begin
            dato_d = dato_out;
            cnt_d  = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dato_q <= '0;
            cnt_q  <= '0;
            modo_q <= OP_AND;
        end else begin
            dato_q <= dato_d;
            cnt_q  <= cnt_d;
            modo_q <= modo_d;
        end
    end

endmodule

// File: rtl/alu_secuencial.sv
// ---------------------------------------------------------------------------
// alu_secuencial
// Registered ALU with valid/ready on both sides. Logic/arithmetic ops take
// one cycle; shifts are iterated bit-serially by unidad_desplazamiento.
//   clk, rst        : clock, synchronous active-high reset
//   expresionA/B    : operands (B is the shift amount for shifts)
//   operacion       : op code (alu_pkg::op_t)
//   entrada_valida  : request valid       entrada_lista : can accept
//   resultado       : registered result   cero/negativo/acarreo/desborde
//   salida_valida   : result valid        salida_lista  : downstream ready
// ---------------------------------------------------------------------------
module alu_secuencial
    import alu_pkg::*;
#(
    parameter int M = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [M-1:0] expresionA,
    input  logic [M-1:0] expresionB,
    input  logic [2:0]   operacion,
    input  logic         entrada_valida,
    output logic         entrada_lista,
    output logic [M-1:0] resultado,
    output logic         cero,
    output logic         negativo,
    output logic         acarreo,
    output logic         desborde,
    output logic         salida_valida,
    input  logic         salida_lista
);

    localparam int         CW    = $clog2(M + 1);
    localparam logic [M:0] M_EXT = (M + 1)'(M);

    estado_t       estado_q, estado_d;
    logic [M-1:0]  resultado_q, resultado_d;
    banderas_t     flags_q, flags_d;

    op_t           op;
    logic          acepta;
    logic          carga;
    logic [CW-1:0] cnt_sat;
    logic [M:0]    suma, resta;
    logic [M-1:0]  alu_res;
    logic          alu_c, alu_v;
    logic [M-1:0]  sh_dato;
    logic          sh_bit, sh_fin;
    logic          actualiza;
    logic [M-1:0]  res_nuevo;
    logic          acarreo_nuevo, desborde_nuevo;

    assign op            = op_t'(operacion);
    assign entrada_lista = (estado_q == REPOSO) || ((estado_q == HECHO) && salida_lista);
    assign acepta        = entrada_valida && entrada_lista;
    assign salida_valida = (estado_q == HECHO);

    // Shifting by M or more gives the same bits as shifting by exactly M.
    assign cnt_sat = ({1'b0, expresionB} >= M_EXT) ? CW'(M) : expresionB[CW-1:0];

    // Single-cycle datapath.
    always_comb begin
        suma    = {1'b0, expresionA} + {1'b0, expresionB};
        resta   = {1'b0, expresionA} - {1'b0, expresionB};
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (op)
            OP_AND: alu_res = expresionA & expresionB;
            OP_OR:  alu_res = expresionA | expresionB;
            OP_XOR: alu_res = expresionA ^ expresionB;
            OP_ADD: begin
                alu_res = suma[M-1:0];
                alu_c   = suma[M];
                alu_v   = (expresionA[M-1] == expresionB[M-1]) &&
                          (suma[M-1] != expresionA[M-1]);
            end
            OP_SUB: begin
                alu_res = resta[M-1:0];
                alu_c   = ~resta[M];   // no borrow <=> A >= B unsigned
                alu_v   = (expresionA[M-1] != expresionB[M-1]) &&
                          (resta[M-1] != expresionA[M-1]);
            end
            default: alu_res = '0;
        endcase
    end

    unidad_desplazamiento #(
        .M  (M),
        .CW (CW)
    ) u_desp (
        .clk      (clk),
        .rst      (rst),
        .load     (carga),
        .modo     (op),
        .dato     (expresionA),
        .cnt      (cnt_sat),
        .dato_out (sh_dato),
        .bit_out  (sh_bit),
        .fin      (sh_fin)
    );

    always_comb begin
        estado_d       = estado_q;
        carga          = 1'b0;
        actualiza      = 1'b0;
        res_nuevo      = resultado_q;
        acarreo_nuevo  = 1'b0;
        desborde_nuevo = 1'b0;
        case (estado_q)
            REPOSO, HECHO: begin
                if (acepta) begin
                    if (es_desplazamiento(op)) begin
                        if (cnt_sat == '0) begin
                            actualiza = 1'b1;
                            res_nuevo = expresionA;
                            estado_d  = HECHO;
                        end else begin
                            carga    = 1'b1;
                            estado_d = DESPLAZA;
                        end
                    end else begin
                        actualiza      = 1'b1;
                        res_nuevo      = alu_res;
                        acarreo_nuevo  = alu_c;
                        desborde_nuevo = alu_v;
                        estado_d       = HECHO;
                    end
                end else if ((estado_q == HECHO) && salida_lista) begin
                    estado_d = REPOSO;
                end
            end
            DESPLAZA: begin
                // Register the look-ahead value on the edge of the last step.
                if (sh_fin) begin
                    actualiza     = 1'b1;
                    res_nuevo     = sh_dato;
                    acarreo_nuevo = sh_bit;
                    estado_d      = HECHO;
                end
            end
            default: estado_d = REPOSO;
        endcase

        resultado_d = resultado_q;
        flags_d     = flags_q;
        // cero/negativo only move with a new result, so reset leaves them 0.
        if (actualiza) begin
            resultado_d      = res_nuevo;
            flags_d.cero     = (res_nuevo == '0);
            flags_d.negativo = res_nuevo[M-1];
            flags_d.acarreo  = acarreo_nuevo;
            flags_d.desborde = desborde_nuevo;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            estado_q    <= REPOSO;
            resultado_q <= '0;
            flags_q     <= '0;
        end else begin
            estado_q    <= estado_d;
            resultado_q <= resultado_d;
            flags_q     <= flags_d;
        end
    end

    assign resultado = resultado_q;
    assign cero      = flags_q.cero;
    assign negativo  = flags_q.negativo;
    assign acarreo   = flags_q.acarreo;
    assign desborde  = flags_q.desborde;

endmodule

// File: tb/tb_alu_secuencial.sv
module tb_alu_secuencial;

    localparam int M = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [M-1:0] expresionA, expresionB;
    logic [2:0]   operacion;
    logic         entrada_valida, entrada_lista;
    logic [M-1:0] resultado;
    logic         cero, negativo, acarreo, desborde;
    logic         salida_valida, salida_lista;

    int checks   = 0;
    int failures = 0;

    alu_secuencial #(.M(M)) dut (
        .clk            (clk),
        .rst            (rst),
        .expresionA     (expresionA),
        .expresionB     (expresionB),
        .operacion      (operacion),
        .entrada_valida (entrada_valida),
        .entrada_lista  (entrada_lista),
        .resultado      (resultado),
        .cero           (cero),
        .negativo       (negativo),
        .acarreo        (acarreo),
        .desborde       (desborde),
        .salida_valida  (salida_valida),
        .salida_lista   (salida_lista)
    );

    always #5 clk = ~clk;

    // Reference: plain integer arithmetic from the op definitions.
    // fl = {cero, negativo, acarreo, desborde}
    function automatic void model(input logic [2:0] op, input logic [M-1:0] a, b,
                                  output logic [M-1:0] r, output logic [3:0] fl,
                                  output int lat);
        int ua, ub, sa, sb, s, n, lo, hi;
        logic c, v;
        ua = int'(a); ub = int'(b);
        sa = a[M-1] ? ua - (1 << M) : ua;
        sb = b[M-1] ? ub - (1 << M) : ub;
        lo = -(1 << (M - 1)); hi = (1 << (M - 1)) - 1;
        n  = (ub > M) ? M : ub;
        c = 1'b0; v = 1'b0; lat = 1; s = 0;
        case (op)
            3'd0: r = a & b;
            3'd1: r = a | b;
            3'd2: r = a ^ b;
            3'd3: begin
                s = ua + ub; r = s[M-1:0]; c = (s >= (1 << M));
                v = (sa + sb > hi) || (sa + sb < lo);
            end
            3'd4: begin
                s = ua - ub; r = s[M-1:0]; c = (ua >= ub);
                v = (sa - sb > hi) || (sa - sb < lo);
            end
            3'd5: begin s = ua << n;  r = s[M-1:0]; c = (n > 0) ? a[M-n] : 1'b0; end
            3'd6: begin s = sa >>> n; r = s[M-1:0]; c = (n > 0) ? a[n-1] : 1'b0; end
            default: begin s = ua >> n; r = s[M-1:0]; c = (n > 0) ? a[n-1] : 1'b0; end
        endcase
        if (op >= 3'd5) lat = (n == 0) ? 1 : n + 1;
        fl = {(r == '0), r[M-1], c, v};
    endfunction

    // Issue one op with salida_lista=0; returns when salida_valida rises
    // (block left holding the result), or with to=1 if a bound expired.
    task automatic send_op(input logic [2:0] op, input logic [M-1:0] a, b,
                           output logic [M-1:0] r, output logic [3:0] fl,
                           output int lat, output bit to);
        int n;
        @(negedge clk);
        operacion = op; expresionA = a; expresionB = b;
        entrada_valida = 1'b1; salida_lista = 1'b0;
        #1;
        n = 0;
        while (!entrada_lista && n < 50) begin @(negedge clk); n++; end
        @(negedge clk);
        entrada_valida = 1'b0;
        lat = 1;
        while (!salida_valida && lat < 50) begin @(negedge clk); lat++; end
        to = !salida_valida || (n >= 50);
        r  = resultado;
        fl = {cero, negativo, acarreo, desborde};
    endtask

    task automatic drain();
        salida_lista = 1'b1;
        @(negedge clk);
        salida_lista = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; entrada_valida = 1'b0; salida_lista = 1'b0;
        operacion = 3'd0; expresionA = '0; expresionB = '0;
        repeat (2) @(negedge clk);
        checks++;
        if ({salida_valida, resultado, cero, negativo, acarreo, desborde} !== '0) begin
            failures++;
            $display("FAIL reset_state got v=%b r=%h f=%b%b%b%b want all zero",
                     salida_valida, resultado, cero, negativo, acarreo, desborde);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (entrada_lista !== 1'b1) begin
            failures++; $display("FAIL reset_ready got=%b want=1", entrada_lista);
        end
    endtask

    task automatic test_directed();
        logic [2:0] ops [5]  = '{3'd3, 3'd5, 3'd5, 3'd6, 3'd7};
        logic [M-1:0] as [5] = '{4'h9, 4'b0011, 4'h6, 4'b1000, 4'b1000};
        logic [M-1:0] bs [5] = '{4'h8, 4'd2, 4'd0, 4'd7, 4'd7};
        logic [M-1:0] r, er; logic [3:0] fl, efl; int lat, elat; bit to;
        for (int i = 0; i < 5; i++) begin
            model(ops[i], as[i], bs[i], er, efl, elat);
            send_op(ops[i], as[i], bs[i], r, fl, lat, to);
            checks++;
            if (to) begin failures++; $display("FAIL dir%0d_timeout got=timeout want=result", i); end
            checks++;
            if ({r, fl} !== {er, efl}) begin
                failures++;
                $display("FAIL dir%0d_value got r=%h f=%b want r=%h f=%b", i, r, fl, er, efl);
            end
            checks++;
            if (lat !== elat) begin
                failures++; $display("FAIL dir%0d_latency got=%0d want=%0d", i, lat, elat);
            end
            drain();
        end
    endtask

    task automatic test_shift_busy();
        // SLL 0011 by 2 with a different op held valid during the shift.
        @(negedge clk);
        operacion = 3'd5; expresionA = 4'b0011; expresionB = 4'd2;
        entrada_valida = 1'b1; salida_lista = 1'b0;
        @(negedge clk);
        operacion = 3'd0; expresionA = 4'hF; expresionB = 4'hF;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if ({entrada_lista, salida_valida} !== 2'b00) begin
                failures++;
                $display("FAIL busy_cycle%0d got rdy=%b vld=%b want 0 0", k, entrada_lista, salida_valida);
            end
            @(negedge clk);
        end
        checks++;
        if ({salida_valida, resultado, cero, negativo, acarreo, desborde} !== {1'b1, 4'b1100, 4'b0100}) begin
            failures++;
            $display("FAIL busy_result got v=%b r=%h f=%b%b%b%b want v=1 r=c f=0100",
                     salida_valida, resultado, cero, negativo, acarreo, desborde);
        end
        entrada_valida = 1'b0;
        drain();
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        salida_lista = 1'b1;
        operacion = 3'd4; expresionA = 4'h3; expresionB = 4'h5; entrada_valida = 1'b1;
        @(negedge clk);
        checks++;
        if ({salida_valida, resultado, cero, negativo, acarreo, desborde} !== {1'b1, 4'hE, 4'b0100}) begin
            failures++;
            $display("FAIL b2b_sub got v=%b r=%h f=%b%b%b%b want v=1 r=e f=0100",
                     salida_valida, resultado, cero, negativo, acarreo, desborde);
        end
        checks++;
        if (entrada_lista !== 1'b1) begin
            failures++; $display("FAIL b2b_ready got=%b want=1", entrada_lista);
        end
        operacion = 3'd2; expresionA = 4'h5; expresionB = 4'h5;
        @(negedge clk);
        entrada_valida = 1'b0;
        checks++;
        if ({salida_valida, resultado, cero} !== {1'b1, 4'h0, 1'b1}) begin
            failures++;
            $display("FAIL b2b_xor got v=%b r=%h z=%b want v=1 r=0 z=1", salida_valida, resultado, cero);
        end
        @(negedge clk);
        checks++;
        if (salida_valida !== 1'b0) begin
            failures++; $display("FAIL b2b_idle got=%b want=0", salida_valida);
        end
        salida_lista = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [M-1:0] r, er, na, nb; logic [3:0] fl, efl; int lat, elat; bit to;
        send_op(3'd3, 4'h9, 4'h8, r, fl, lat, to);
        checks++;
        if (to) begin failures++; $display("FAIL bp_timeout got=timeout want=result"); end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if ({salida_valida, entrada_lista, resultado, cero, negativo, acarreo, desborde} !==
                {1'b1, 1'b0, 4'h1, 4'b0011}) begin
                failures++;
                $display("FAIL bp_hold%0d got v=%b rdy=%b r=%h f=%b%b%b%b want v=1 rdy=0 r=1 f=0011",
                         k, salida_valida, entrada_lista, resultado, cero, negativo, acarreo, desborde);
            end
        end
        na = M'($urandom); nb = M'($urandom);
        model(3'd0, na, nb, er, efl, elat);
        operacion = 3'd0; expresionA = na; expresionB = nb;
        entrada_valida = 1'b1; salida_lista = 1'b1;
        #1;
        checks++;
        if (entrada_lista !== 1'b1) begin
            failures++; $display("FAIL bp_release_ready got=%b want=1", entrada_lista);
        end
        @(negedge clk);
        entrada_valida = 1'b0;
        checks++;
        if ({salida_valida, resultado, cero, negativo, acarreo, desborde} !== {1'b1, er, efl}) begin
            failures++;
            $display("FAIL bp_new_op got v=%b r=%h f=%b%b%b%b want v=1 r=%h f=%b",
                     salida_valida, resultado, cero, negativo, acarreo, desborde, er, efl);
        end
        @(negedge clk);
        salida_lista = 1'b0;
    endtask

    task automatic test_reset_mid_shift();
        logic [M-1:0] r; logic [3:0] fl; int lat; bit to; bit seen;
        // Leave a non-zero result behind so the clear is visible.
        send_op(3'd1, 4'h5, 4'h2, r, fl, lat, to);
        drain();
        @(negedge clk);
        operacion = 3'd7; expresionA = 4'b1011; expresionB = 4'd3;
        entrada_valida = 1'b1; salida_lista = 1'b1;
        @(negedge clk);
        entrada_valida = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({salida_valida, resultado, cero, negativo, acarreo, desborde} !== '0 || entrada_lista !== 1'b1) begin
            failures++;
            $display("FAIL rst_mid got v=%b rdy=%b r=%h f=%b%b%b%b want v=0 rdy=1 r=0 f=0000",
                     salida_valida, entrada_lista, resultado, cero, negativo, acarreo, desborde);
        end
        seen = 1'b0;
        repeat (6) begin @(negedge clk); if (salida_valida) seen = 1'b1; end
        checks++;
        if (seen !== 1'b0) begin
            failures++; $display("FAIL rst_aborted got=result_seen want=none");
        end
        salida_lista = 1'b0;
    endtask

    task automatic test_random();
        logic [2:0] op; logic [M-1:0] a, b, r, er; logic [3:0] fl, efl;
        int lat, elat; bit to;
        repeat (40) begin
            op = 3'($urandom_range(0, 7));
            a  = M'($urandom);
            b  = M'($urandom);
            model(op, a, b, er, efl, elat);
            send_op(op, a, b, r, fl, lat, to);
            checks++;
            if (to || {r, fl} !== {er, efl} || lat !== elat) begin
                failures++;
                $display("FAIL rand op=%0d a=%h b=%h got r=%h f=%b lat=%0d to=%b want r=%h f=%b lat=%0d",
                         op, a, b, r, fl, lat, to, er, efl, elat);
            end
            drain();
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_shift_busy();
        test_back_to_back();
        test_backpressure();
        test_reset_mid_shift();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_secuencial.md
Name: alu_secuencial

Overview:
- Parametrised, registered ALU: logic, arithmetic and multi-cycle serial shift operations on M-bit operands, with a full flag set (cero, negativo, acarreo, desborde).
- Valid/ready handshake on input and output, so it drops into the datapath between operand registers and the writeback stage.
- Single-cycle ops: 1-cycle latency. Shifts: iterated one bit per cycle by an internal FSM.

Parameters:
- M, 4, operand/result width in bits (M >= 2).
- CW, $clog2(M+1), derived localparam: width of the shift counter.

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- expresionA  input  M  operand A
- expresionB  input  M  operand B; shift amount for shift ops
- operacion  input  3  op code (see Behaviour)
- entrada_valida  input  1  operands/op valid
- entrada_lista  output  1  block can accept an op this cycle
- resultado  output  M  registered result
- cero  output  1  resultado == 0
- negativo  output  1  resultado[M-1]
- acarreo  output  1  carry / no-borrow / last bit shifted out
- desborde  output  1  signed overflow (ADD/SUB only, else 0)
- salida_valida  output  1  resultado and flags valid
- salida_lista  input  1  downstream accepts result

Behaviour:
- Op codes: 000 AND, 001 OR, 010 XOR, 011 ADD, 100 SUB (A-B), 101 SLL, 110 SRA, 111 SRL.
- Reset (rst=1 at a clock edge): estado=REPOSO; resultado=0; all flags=0; salida_valida=0; counter=0. Reset aborts any in-flight op, including mid-shift, and no result is produced.
- Accept: an op is accepted when entrada_valida && entrada_lista. entrada_lista = (estado==REPOSO) || (estado==HECHO && salida_lista). This gives back-to-back throughput of 1 op/cycle for single-cycle ops.
- FSM states: REPOSO, DESPLAZA, HECHO.
  - REPOSO/HECHO, on accept of a single-cycle op: the result and flags are registered and the FSM goes to HECHO. salida_valida=1 on the next cycle (latency 1).
  - On accept of a shift: cnt = (B >= M) ? M : B[CW-1:0]. If cnt==0, register A unchanged with acarreo=0 and go to HECHO (latency 1). Otherwise load A into the shift register and cnt into the counter, then go to DESPLAZA.
  - DESPLAZA: each cycle, shift by 1 (SLL fills 0; SRL fills 0; SRA replicates the MSB), capture the shifted-out bit into acarreo, and decrement the counter. When the counter reaches 1, go to HECHO. Latency = cnt+1 cycles. entrada_lista=0 and entrada_valida is ignored.
  - HECHO: resultado and flags are held stable while salida_lista=0. On salida_lista=1 with no new accept, go to REPOSO and drop salida_valida. If a new op is accepted in the same cycle, take the accept path above.
- Arithmetic (M+1-bit internal sum):
  - ADD: acarreo = bit M of the sum.
  - SUB: acarreo = 1 when A >= B unsigned (no borrow).
  - desborde = signed overflow: operand MSBs equal and result MSB differs (ADD), or operand MSBs differ and result MSB differs from A (SUB).
  - Logic ops: acarreo=0, desborde=0.
- cero and negativo are derived from the final registered resultado for every op.
- While salida_valida=0, outputs keep their last values and downstream must not sample them.

Decomposition:
- Package alu_pkg:
  - typedef enum logic [2:0] op_t (OP_AND..OP_SRL)
  - typedef enum logic [1:0] estado_t (REPOSO, DESPLAZA, HECHO)
  - typedef struct packed banderas_t {cero, negativo, acarreo, desborde}
- One sub-module, unidad_desplazamiento: holds the serial shift register, the down-counter and the shifted-out bit. Inputs: load, modo, dato, cnt. Outputs: dato_out, bit_out, fin.

Test Plan (M=4):
- ADD A=4'h9, B=4'h8 -> 1 cycle later salida_valida=1, resultado=4'h1, acarreo=1, desborde=1, cero=0, negativo=0.
- SUB A=4'h3, B=4'h5, then XOR A=4'h5, B=4'h5 back-to-back with salida_lista=1 -> 4'hE (acarreo=0, negativo=1, desborde=0), then next cycle 4'h0 with cero=1; entrada_lista stays 1.
- SLL A=4'b0011, B=2 -> entrada_lista=0 for 2 cycles; result at cycle 3 = 4'b1100, acarreo=0, negativo=1. SLL with B=0 -> A returned at latency 1.
- SRA A=4'b1000, B=7 (saturates to 4) -> latency 5, resultado=4'b1111, acarreo=1. SRL same inputs -> 4'b0000, cero=1, acarreo=1.
- Backpressure: hold salida_lista=0 for 3 cycles after ADD -> resultado/flags stable and entrada_lista=0; release it with a new op already valid -> accepted that cycle.
- Assert rst during the 2nd cycle of DESPLAZA -> next cycle estado=REPOSO, salida_valida=0, resultado=0, flags=0; the aborted op never produces a result.
